// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one shared full_adder cell.
// Operands are shifted out LSB first, one bit per clock, with the carry kept in a flop
// between bits. The result is presented through a registered start/done handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a `sub` input exists. With sub=1 the B register loads ~b and the
//   carry flop loads 1, so the block computes a - b (cout=1 means no borrow).
//   When undefined, the block is add-only and has no `sub` port.

// Single-bit full adder cell; the controller below time-multiplexes one instance.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum/carry of three input bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter is 5 bits wide, which covers the full 2..32 width range.
    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic             carry_q, carry_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Operand values as they should be loaded on an accepting edge.
    logic [WIDTH-1:0] load_b;
    logic             load_carry;

    // Shared adder cell: always looks at bit 0 of the operand registers.
    logic fa_sum;
    logic fa_cout;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Select what the B register and carry flop load; subtract inverts B and forces carry 1.
    always_comb begin
        load_b     = b;
        load_carry = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            load_b     = ~b;
            load_carry = 1'b1;
        end
`endif
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            // IDLE and DONE both accept a new request; DONE only differs in its output.
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    opa_d   = a;
                    opb_d   = load_b;
                    carry_d = load_carry;
                    cnt_d   = 5'd0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            // One bit per edge; the result register fills from the MSB end so the
            // last bit lands it in natural order. start is ignored here.
            S_SHIFT: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; synchronous reset aborts any operation and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= 5'd0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Sequences a single shared `full_adder` instance to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock, carry held in a register between bits.
- Sits between the operand source (switches or upstream logic) and the 7-segment display path.
- Presents a registered result with a start/done handshake.
- Trades latency for area: one full-adder cell serves the whole word.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new addition; sampled on the rising edge.
- `a`  input  WIDTH: operand A; captured on the accepting edge.
- `b`  input  WIDTH: operand B; captured on the accepting edge.
- `cin`  input  1: carry-in for bit 0; captured on the accepting edge.
- `sub`  input  1: subtract select; present only with `SERIAL_ADDER_SUB_EN`.
- `busy`  output  1: high while bits are being processed.
- `done`  output  1: one-cycle pulse when `sum`/`cout` update.
- `sum`  output  WIDTH: registered result of the last completed operation.
- `cout`  output  1: registered carry out of bit WIDTH-1 of the last completed operation.

## Operation
- Datapath:
  - One `full_adder` instance (ports `a`, `b`, `cin`, `sum`, `cout`) is fed from bit 0 of two operand shift registers and a carry flip-flop.
  - A 5-bit bit counter tracks progress.
  - An internal result shift register collects sum bits MSB-inward.
- FSM states:
  - IDLE: `busy`=0, `done`=0. If `start`=1, latch `a`, `b`, `cin` into the operand registers and carry FF, clear the counter, go to SHIFT.
  - SHIFT: `busy`=1. Each edge:
    - shift the full-adder sum bit into the result register;
    - load the carry FF from the full-adder cout;
    - shift both operand registers right by one;
    - increment the counter.
    - When the counter reaches WIDTH-1 on this edge, go to DONE and copy the completed result register into `sum` and the final carry into `cout` on the same edge.
  - DONE: `done`=1, `busy`=0 for exactly one cycle. If `start`=1, accept it exactly as in IDLE and go to SHIFT; otherwise go to IDLE.
- `start` is ignored while in SHIFT. There is no queueing: a request is accepted or dropped.
- `sum`/`cout` hold the previous result for the entire SHIFT phase. They change only on the edge that enters DONE.
- Arithmetic: the result equals `(a + b + cin) mod 2^WIDTH`, with `cout` as bit WIDTH of the true sum.
- Operand inputs may change freely after the accepting edge without affecting the operation in flight.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0. The operand registers, carry FF and counter are also cleared.
- Reset asserted mid-operation:
  - Aborts the operation on that edge.
  - No `done` pulse is produced.
  - `sum`/`cout` become 0.
  - Reset has priority over `start`.
- Latency:
  - `start` is accepted at edge E0.
  - `busy` is high from after E0 through E(WIDTH).
  - `done` is high during the cycle after E(WIDTH), with `sum` valid in that same cycle.
- Throughput:
  - Back-to-back via DONE: one result every WIDTH+1 cycles.
  - Start from IDLE: also WIDTH+1 cycles from the accepting edge to the end of the `done` cycle.
- `busy` and `done` are never high simultaneously.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Port `sub` exists and is captured with the operands.
  - When `sub`=1, the B shift register loads `~b` and the carry FF loads 1 (`cin` is ignored), giving `a - b`.
  - `cout`=1 means no borrow (a ≥ b unsigned).
  - When `sub`=0, behaviour is identical to the base block.
- `SERIAL_ADDER_SUB_EN` not defined: no `sub` port; add-only behaviour as described above.

## Test plan
- Basic add, WIDTH=8: `a`=0x5A, `b`=0x33, `cin`=0, `start` pulse.
  - `busy` is high for 8 cycles.
  - `done` pulses exactly one cycle later, with `sum`=0x8D, `cout`=0.
- Wrap-around and carry-in:
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - `a`=0x00, `b`=0x00, `cin`=1 → `sum`=0x01, `cout`=0.
  - `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- Ignored start:
  - Assert `start` with `a`=0x10, `b`=0x20; then on cycle 3 of SHIFT re-assert `start` with `a`=0xAA, `b`=0x55.
  - Exactly one `done` pulse, with `sum`=0x30.
  - `sum` holds its prior value until that pulse.
- Back-to-back: hold `start`=1 continuously with operands (0x01,0x02), then (0x03,0x04).
  - `done` pulses 9 cycles apart, with `sum`=0x03 and then `sum`=0x07.
- Reset mid-operation: assert `rst` for one cycle in SHIFT bit 4.
  - `busy`=0, `sum`=0, `cout`=0 after that edge; no `done` pulse.
  - A subsequent start with 0x22+0x11 yields 0x33.
- Subtract (with `SERIAL_ADDER_SUB_EN`):
  - `a`=0x10, `b`=0x01, `sub`=1 → `sum`=0x0F, `cout`=1.
  - `a`=0x01, `b`=0x02, `sub`=1 → `sum`=0xFF, `cout`=0.
